// File: rtl/sync_filter_pkg.sv
// sync_filter_pkg: shared defaults, counter sizing helper and the per-channel
// state record used by the multi-channel synchronizer/filter.
package sync_filter_pkg;

  // Default build configuration.
  localparam int DEF_NUM_CHANNELS = 4;
  localparam int DEF_NUM_STAGES   = 2;
  localparam int DEF_FILTER_CNT   = 4;

  // Widths of the state record fields. The record carries the widest chain
  // and counter a channel may be built with; narrower channels zero-extend.
  localparam int MAX_STAGES = 8;
  localparam int MAX_CNT_W  = 8;

  // Width of a counter that must hold values 0..filter_cnt.
  function automatic int cnt_width(input int filter_cnt);
    return $clog2(filter_cnt + 1);
  endfunction

  // Snapshot of one channel: synchronizer chain, stability count, output level.
  typedef struct packed {
    logic [MAX_STAGES-1:0] sync;
    logic [MAX_CNT_W-1:0]  cnt;
    logic                  dout;
  } chan_state_t;

endpackage

// File: rtl/sync_filter_chan.sv
// sync_filter_chan: one channel of the synchronizer + stability filter.
//   din   -> NUM_STAGES-deep synchronizer -> sync_b
//   sync_b -> stability filter (filt_en=1) or straight load (filt_en=0) -> dout
//   dout transitions -> registered rise/fall pulses aligned with the new dout.
// Edge pulses exist only when SYNC_FILTER_EDGE_DETECT_EN is defined; otherwise
// rise/fall are constant 0 and no edge flops are built.
module sync_filter_chan
  import sync_filter_pkg::*;
#(
  parameter int NUM_STAGES = DEF_NUM_STAGES,
  parameter int FILTER_CNT = DEF_FILTER_CNT
) (
  input  logic        clkB,
  input  logic        rstB,
  input  logic        din,
  input  logic        filt_en,
  output logic        dout,
  output logic        rise,
  output logic        fall,
  output chan_state_t state
);

  localparam int CW = cnt_width(FILTER_CNT);

  // Synchronizer chain: bit 0 samples the asynchronous input, the MSB is the
  // first stage considered safe to use.
  (* ASYNC_REG = "TRUE" *) logic [NUM_STAGES-1:0] sync_q;

  logic          sync_b;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          dout_q;
  logic          dout_d;

  assign sync_b = sync_q[NUM_STAGES-1];

  // Synchronizer shift register; pure flop-to-flop, nothing in between.
  always_ff @(posedge clkB) begin
    if (rstB) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[NUM_STAGES-2:0], din};
    end
  end

  // Filter next state. A disagreement between sync_b and dout must persist for
  // FILTER_CNT consecutive samples before dout follows; any agreement clears
  // the count. In bypass the count is held at 0 so re-enabling starts fresh.
  always_comb begin
    cnt_d  = '0;
    dout_d = dout_q;
    if (!filt_en) begin
      dout_d = sync_b;
    end else if (sync_b != dout_q) begin
      if (cnt_q == CW'(FILTER_CNT - 1)) begin
        dout_d = sync_b;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // Filter state register.
  always_ff @(posedge clkB) begin
    if (rstB) begin
      cnt_q  <= '0;
      dout_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      dout_q <= dout_d;
    end
  end

  assign dout = dout_q;

`ifdef SYNC_FILTER_EDGE_DETECT_EN
  logic rise_q;
  logic fall_q;

  // Edge pulses are computed from the same next-state value that loads dout,
  // so each pulse lands in the cycle dout first shows the new level.
  always_ff @(posedge clkB) begin
    if (rstB) begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      rise_q <= dout_d & ~dout_q;
      fall_q <= ~dout_d & dout_q;
    end
  end

  assign rise = rise_q;
  assign fall = fall_q;
`else
  assign rise = 1'b0;
  assign fall = 1'b0;
`endif

  // Observation tap for checkers: the channel's full state, zero-extended.
  always_comb begin
    state      = '0;
    state.sync = MAX_STAGES'(sync_q);
    state.cnt  = MAX_CNT_W'(cnt_q);
    state.dout = dout_q;
  end

endmodule

// File: rtl/multi_channel_sync_filter.sv
// multi_channel_sync_filter: NUM_CHANNELS independent single-bit channels,
// each synchronized into clkB, optionally stability-filtered, with one-cycle
// rise/fall pulses on every output transition.
// Optional feature macro: SYNC_FILTER_EDGE_DETECT_EN (edge pulses; when
// undefined riseB/fallB are tied to 0).
module multi_channel_sync_filter
  import sync_filter_pkg::*;
#(
  parameter int NUM_CHANNELS = DEF_NUM_CHANNELS,
  parameter int NUM_STAGES   = DEF_NUM_STAGES,
  parameter int FILTER_CNT   = DEF_FILTER_CNT
) (
  input  logic                    clkB,
  input  logic                    rstB,
  input  logic [NUM_CHANNELS-1:0] dinA,
  input  logic                    filt_en,
  output logic [NUM_CHANNELS-1:0] doutB,
  output logic [NUM_CHANNELS-1:0] riseB,
  output logic [NUM_CHANNELS-1:0] fallB
);

  // Per-channel state taps, kept as a bind point for checkers.
  chan_state_t chan_state [NUM_CHANNELS];

  for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_chan
    sync_filter_chan #(
      .NUM_STAGES (NUM_STAGES),
      .FILTER_CNT (FILTER_CNT)
    ) u_chan (
      .clkB    (clkB),
      .rstB    (rstB),
      .din     (dinA[i]),
      .filt_en (filt_en),
      .dout    (doutB[i]),
      .rise    (riseB[i]),
      .fall    (fallB[i]),
      .state   (chan_state[i])
    );

    // The taps feed no logic inside this block.
    logic unused_state;
    assign unused_state = ^{chan_state[i].sync, chan_state[i].cnt, chan_state[i].dout};
  end

endmodule

// File: doc/multi_channel_sync_filter.md
MULTI_CHANNEL_SYNC_FILTER -- requirements
Module: multi_channel_sync_filter

Interface
REQ-001 SHALL have parameter NUM_CHANNELS, default 4: number of independent single-bit channels.
REQ-002 SHALL have parameter NUM_STAGES, default 2: synchronizer flop stages per channel; legal range 2 or more.
REQ-003 SHALL have parameter FILTER_CNT, default 4: consecutive stable cycles required before the output changes; legal range 1 or more.
REQ-004 SHALL have port clkB, input, 1 bit: the single destination clock; all state is on its rising edge.
REQ-005 SHALL have port rstB, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port dinA, input, NUM_CHANNELS bits: asynchronous level inputs, one per channel.
REQ-007 SHALL have port filt_en, input, 1 bit, synchronous to clkB: 1 enables the stability filter; 0 bypasses it.
REQ-008 SHALL have port doutB, output, NUM_CHANNELS bits: the synchronized, filtered level of each channel.
REQ-009 SHALL have port riseB, output, NUM_CHANNELS bits: a one-cycle pulse when the doutB bit goes 0 to 1.
REQ-010 SHALL have port fallB, output, NUM_CHANNELS bits: a one-cycle pulse when the doutB bit goes 1 to 0.

Function
REQ-011 Each channel SHALL pass dinA through NUM_STAGES flops in series; the last stage is syncB, and no logic sits between the stages.
REQ-012 All synchronizer flops SHALL carry the ASYNC_REG="TRUE" attribute.
REQ-013 Each channel SHALL hold a counter cnt of width $clog2(FILTER_CNT+1).
REQ-014 With filt_en=1 and syncB equal to doutB, cnt SHALL clear to 0.
REQ-015 With filt_en=1 and syncB not equal to doutB:
- if cnt equals FILTER_CNT-1, doutB SHALL load syncB and cnt SHALL clear;
- otherwise cnt SHALL increment.
REQ-016 Net filtered latency SHALL be NUM_STAGES+FILTER_CNT clkB edges from the first edge that samples a new dinA level to the edge that updates doutB.
REQ-017 A syncB excursion shorter than FILTER_CNT cycles SHALL leave doutB unchanged and produce no pulse; cnt SHALL clear when the excursion ends.
REQ-018 With filt_en=0:
- doutB SHALL load syncB every cycle, giving a latency of NUM_STAGES+1;
- cnt SHALL be held at 0.
REQ-019 A change of filt_en SHALL take effect on the next edge; any partial count SHALL be discarded.
REQ-020 riseB and fallB SHALL be registered and asserted in the same cycle that doutB shows the new level, for exactly one cycle per transition.
REQ-021 Channels SHALL be fully independent; simultaneous transitions on any channels SHALL each be handled with identical latency.
REQ-022 riseB and fallB SHALL never be asserted together for the same channel.

Reset
REQ-023 While rstB=1 at a clkB edge, the following SHALL clear to 0: all synchronizer flops, cnt, doutB, riseB and fallB.
REQ-024 Reset SHALL have priority over every other event, including an update in progress; the count restarts from 0 after release.
REQ-025 If dinA=1 at reset release, the channel SHALL treat it as a normal 0-to-1 transition: doutB rises after the REQ-016 latency and riseB pulses.

Configuration
REQ-026 Macro SYNC_FILTER_EDGE_DETECT_EN SHALL control the edge-detect logic.
- Defined: riseB and fallB behave per REQ-020.
- Undefined: the riseB and fallB ports remain present, are tied to constant 0, and no edge flops are instantiated.

Structure
REQ-027 Package sync_filter_pkg SHALL hold:
- default parameter constants;
- function cnt_width(FILTER_CNT);
- typedef chan_state_t (sync chain, cnt, dout).
REQ-028 A per-channel sub-module sync_filter_chan SHALL implement REQ-011 to REQ-022; the top SHALL instantiate NUM_CHANNELS of them through a generate loop.

Verification (NUM_CHANNELS=4, NUM_STAGES=2, FILTER_CNT=4 unless noted)
REQ-029 Reset with dinA=4'b0000 held for 20 cycles -> doutB=0, riseB=0, fallB=0 throughout.
REQ-030 dinA[0] 0 to 1 and held -> doutB[0]=1 at edge 6 after the first sampling edge; riseB[0]=1 for exactly that cycle; later 1 to 0 -> fallB[0] pulses at edge 6.
REQ-031 dinA[1] high for 3 cycles, then high for 4 cycles:
- 3 cycles -> doutB[1] stays 0, no pulse;
- 4 cycles -> doutB[1] rises.
REQ-032 filt_en=0, dinA[2] high for 1 cycle -> doutB[2] high for exactly 1 cycle at latency 3, with a riseB[2] and fallB[2] pair.
REQ-033 rstB asserted 2 cycles into a 4-cycle count on dinA[3] -> all outputs 0; after release doutB[3] needs a full 6 cycles to rise.
REQ-034 All four dinA bits toggle on the same edge -> all doutB bits update on the same edge.
- Rebuilt without SYNC_FILTER_EDGE_DETECT_EN -> riseB and fallB stay 0 for the whole test.
